shot_rising: RTL and testbench

- Controls the player's shot as it travels upward toward the alien formation; this is the counterpart of the alien-falling path.
- On `fire`, it latches the launch column and walks the shot up the screen at a fixed rate.
- Each step is an erase/redraw handshake with the VGA drawing engine.
- The flight ends with a one-cycle `hit` pulse when the shot reaches the alien row within its x-span, or a `miss` pulse when it reaches the top row.

---
 rtl/game_pkg.sv | 28 ++
 rtl/shot_rising_if.sv | 36 +++
 rtl/shot_tick_divider.sv | 40 ++++
 rtl/shot_rising.sv | 136 +++++++++++++
 tb/tb_shot_rising.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: shot FSM encoding and screen geometry, common to the
// rising-shot and alien-falling paths.
package game_pkg;

    localparam int X_WIDTH = 8;
    localparam int Y_WIDTH = 7;
    localparam int START_Y = 110;
    localparam int TOP_ROW = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        WAIT  = 2'd2,
        ERASE = 2'd3
    } shot_state_e;

    // Cycles per shot step; never below one, even for a degenerate rate.
    function automatic int unsigned period_cycles(input int unsigned clock_frequency,
                                                  input int unsigned rate);
        int unsigned p;
        if (rate == 0) begin
            return 1;
        end
        p = clock_frequency / rate;
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/shot_rising_if.sv
// Game-side and VGA-side signals of the rising shot, bundled for port hookup.
// master: the shot controller; slave: the game logic and VGA engine around it.
interface shot_rising_if #(
    parameter int X_WIDTH = game_pkg::X_WIDTH,
    parameter int Y_WIDTH = game_pkg::Y_WIDTH
);
    logic               fire;
    logic [X_WIDTH-1:0] player_x;
    logic               halt;
    logic [Y_WIDTH-1:0] alien_y;
    logic [X_WIDTH-1:0] alien_x_min;
    logic [X_WIDTH-1:0] alien_x_max;
    logic               alien_alive;
    logic               draw_done;

    logic [X_WIDTH-1:0] shot_x;
    logic [Y_WIDTH-1:0] shot_y;
    logic               draw_req;
    logic               erase;
    logic               busy;
    logic               hit;
    logic               miss;

    modport master (
        input  fire, player_x, halt, alien_y, alien_x_min, alien_x_max,
               alien_alive, draw_done,
        output shot_x, shot_y, draw_req, erase, busy, hit, miss
    );

    modport slave (
        output fire, player_x, halt, alien_y, alien_x_min, alien_x_max,
               alien_alive, draw_done,
        input  shot_x, shot_y, draw_req, erase, busy, hit, miss
    );

endinterface

// File: rtl/shot_tick_divider.sv
// Loadable down-counter pacing the shot: load sets PERIOD-1, en counts down and
// holds at zero, tick flags a zero count.
module shot_tick_divider #(
    parameter int unsigned PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: count_d gets its default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: registers take <= so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == '0);

endmodule

// File: rtl/shot_rising.sv
// Player shot controller: launches from the player column, steps upward through
// draw/wait/erase handshakes with the VGA engine, and ends in a hit or miss pulse.
module shot_rising
    import game_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
    parameter int unsigned SHOT_RATE       = 3,
    parameter int          X_WIDTH         = game_pkg::X_WIDTH,
    parameter int          Y_WIDTH         = game_pkg::Y_WIDTH,
    parameter int unsigned START_Y         = game_pkg::START_Y,
    parameter int unsigned STEP            = 1
) (
    input  logic          clk,
    input  logic          reset,
    shot_rising_if.master bus
);

    localparam int unsigned        PERIOD    = period_cycles(CLOCK_FREQUENCY, SHOT_RATE);
    localparam logic [Y_WIDTH-1:0] START_ROW = Y_WIDTH'(START_Y);
    localparam logic [Y_WIDTH-1:0] STEP_Y    = Y_WIDTH'((STEP < 1) ? 1 : STEP);
    localparam logic [Y_WIDTH-1:0] TOP_Y     = Y_WIDTH'(TOP_ROW);

    shot_state_e        state_q, state_d;
    logic [X_WIDTH-1:0] shot_x_q, shot_x_d;
    logic [Y_WIDTH-1:0] shot_y_q, shot_y_d;
    logic               abort_q, abort_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic               div_load;
    logic               div_en;
    logic               tick;
    logic [Y_WIDTH-1:0] next_y;
    logic               hit_cond;

    shot_tick_divider #(
        .PERIOD (PERIOD)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .load_i (div_load),
        .en_i   (div_en),
        .tick_o (tick)
    );

    // The shot saturates at the top row rather than wrapping to the bottom.
    assign next_y   = (shot_y_q >= STEP_Y) ? (shot_y_q - STEP_Y) : '0;
    assign hit_cond = bus.alien_alive
                   && (next_y <= bus.alien_y)
                   && (bus.alien_x_min <= shot_x_q)
                   && (shot_x_q <= bus.alien_x_max);

    always_comb begin
        state_d  = state_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        abort_d  = abort_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        div_load = 1'b0;
        div_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.fire && !bus.halt) begin
                    shot_x_d = bus.player_x;
                    shot_y_d = START_ROW;
                    abort_d  = 1'b0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (bus.draw_done) begin
                    div_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                div_en = 1'b1;
                if (bus.halt) begin
                    abort_d = 1'b1;
                    state_d = ERASE;
                end else if (tick) begin
                    state_d = ERASE;
                end
            end
            ERASE: begin
                // Abort outranks miss, which outranks hit; alien inputs matter only here.
                if (bus.draw_done) begin
                    if (abort_q) begin
                        state_d = IDLE;
                    end else if (shot_y_q == TOP_Y) begin
                        miss_d  = 1'b1;
                        state_d = IDLE;
                    end else if (hit_cond) begin
                        shot_y_d = next_y;
                        hit_d    = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        shot_y_d = next_y;
                        state_d  = DRAW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: shot position is reset along with the FSM because it is driven straight to the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shot_x_q <= '0;
            shot_y_q <= '0;
            abort_q  <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shot_x_q <= shot_x_d;
            shot_y_q <= shot_y_d;
            abort_q  <= abort_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.shot_x   = shot_x_q;
    assign bus.shot_y   = shot_y_q;
    assign bus.draw_req = (state_q == DRAW) || (state_q == ERASE);
    assign bus.erase    = (state_q == ERASE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.hit      = hit_q;
    assign bus.miss     = miss_q;

endmodule

// File: tb/tb_shot_rising.sv
// Scoreboard bench for shot_rising: expected draw/erase/hit/miss events are queued
// as each flight is launched and compared against events seen on the bus.
module tb_shot_rising;
    import game_pkg::*;

    localparam int XW = 8;
    localparam int YW = 7;

    typedef enum logic [1:0] {K_DRAW, K_ERASE, K_HIT, K_MISS} kind_e;
    typedef struct packed {
        kind_e          kind;
        logic           busy;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    shot_rising_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    shot_rising #(
        .CLOCK_FREQUENCY (12),
        .SHOT_RATE       (3),
        .X_WIDTH         (XW),
        .Y_WIDTH         (YW),
        .START_Y         (10),
        .STEP            (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // VGA engine model: acknowledges each request one cycle after it appears.
    initial begin
        bus.draw_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.draw_done = bus.draw_req && !bus.draw_done;
        end
    end

    // Bus monitor: a completed handshake or a pulse becomes one observed event.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.draw_req && bus.draw_done)
                    obs_q.push_back(mk(bus.erase ? K_ERASE : K_DRAW, bus.busy, bus.shot_x, bus.shot_y));
                if (bus.hit)
                    obs_q.push_back(mk(K_HIT, bus.busy, bus.shot_x, bus.shot_y));
                if (bus.miss)
                    obs_q.push_back(mk(K_MISS, bus.busy, bus.shot_x, bus.shot_y));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ev_t mk(input kind_e k, input logic b, input logic [XW-1:0] x,
                               input logic [YW-1:0] y);
        ev_t e;
        e.kind = k;
        e.busy = b;
        e.x    = x;
        e.y    = y;
        return e;
    endfunction

    task automatic push_steps(input int x, input int y_hi, input int y_lo);
        for (int y = y_hi; y >= y_lo; y -= 2) begin
            exp_q.push_back(mk(K_DRAW, 1'b1, XW'(x), YW'(y)));
            exp_q.push_back(mk(K_ERASE, 1'b1, XW'(x), YW'(y)));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_aliens(input logic alive, input int ay, input int xmin, input int xmax);
        bus.alien_alive = alive;
        bus.alien_y     = YW'(ay);
        bus.alien_x_min = XW'(xmin);
        bus.alien_x_max = XW'(xmax);
    endtask

    task automatic launch(input int x);
        bus.player_x = XW'(x);
        bus.fire     = 1'b1;
        step(1);
        bus.fire     = 1'b0;
    endtask

    // Polls on falling edges until busy drops; returns on the busy-fall cycle.
    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, bus.busy, k);
        end
    endtask

    task automatic test_reset();
        bus.fire = 1'b0;
        bus.halt = 1'b0;
        bus.player_x = '0;
        set_aliens(1'b0, 0, 0, 0);
        reset = 1'b1;
        step(3);
        @(negedge clk);
        n_checks++;
        if ({bus.shot_x, bus.shot_y, bus.draw_req, bus.erase, bus.busy, bus.hit, bus.miss} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: x=%0d y=%0d req=%b erase=%b busy=%b hit=%b miss=%b, required all 0",
                     bus.shot_x, bus.shot_y, bus.draw_req, bus.erase, bus.busy, bus.hit, bus.miss);
        end
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE);
        end
        n_checks++;
        if (dut.u_div.count_q !== '0) begin
            n_fail++;
            $display("FAIL reset_divider: got %0d required 0", dut.u_div.count_q);
        end
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_miss_path();
        ev_t e, o;
        set_aliens(1'b0, 5, 40, 60);
        push_steps(50, 10, 0);
        exp_q.push_back(mk(K_MISS, 1'b0, 8'd50, 7'd0));
        launch(50);
        @(negedge clk);
        n_checks++;
        if ({bus.draw_req, bus.erase, bus.busy, bus.shot_x, bus.shot_y} !== {1'b1, 1'b0, 1'b1, 8'd50, 7'd10}) begin
            n_fail++;
            $display("FAIL miss_launch: req=%b erase=%b busy=%b x=%0d y=%0d, required 1 0 1 50 10",
                     bus.draw_req, bus.erase, bus.busy, bus.shot_x, bus.shot_y);
        end
        wait_idle("miss_path");
        n_checks++;
        if ({bus.miss, bus.hit} !== 2'b10) begin
            n_fail++;
            $display("FAIL miss_pulse_at_busy_fall: miss=%b hit=%b, required 1 0", bus.miss, bus.hit);
        end
        @(negedge clk);
        n_checks++;
        if (bus.miss !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_pulse_width: miss=%b one cycle later, required 0", bus.miss);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL miss_path_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL miss_path_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    task automatic test_hit_path();
        ev_t e, o;
        set_aliens(1'b1, 5, 40, 60);
        push_steps(50, 10, 6);
        exp_q.push_back(mk(K_HIT, 1'b0, 8'd50, 7'd4));
        launch(50);
        wait_idle("hit_path");
        n_checks++;
        if ({bus.hit, bus.miss, bus.shot_y} !== {1'b1, 1'b0, 7'd4}) begin
            n_fail++;
            $display("FAIL hit_pulse: hit=%b miss=%b y=%0d, required 1 0 4", bus.hit, bus.miss, bus.shot_y);
        end
        step(10);
        @(negedge clk);
        n_checks++;
        if ({bus.draw_req, bus.busy, bus.hit} !== 3'b000) begin
            n_fail++;
            $display("FAIL hit_no_redraw: req=%b busy=%b hit=%b, required 0 0 0", bus.draw_req, bus.busy, bus.hit);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hit_path_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL hit_path_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    task automatic test_span_miss();
        ev_t e, o;
        set_aliens(1'b1, 5, 40, 60);
        push_steps(61, 10, 0);
        exp_q.push_back(mk(K_MISS, 1'b0, 8'd61, 7'd0));
        launch(61);
        wait_idle("span_miss");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL span_miss_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL span_miss_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        set_aliens(1'b0, 5, 40, 60);
        push_steps(50, 10, 0);
        exp_q.push_back(mk(K_MISS, 1'b0, 8'd50, 7'd0));
        exp_q.push_back(mk(K_DRAW, 1'b1, 8'd50, 7'd10));
        bus.player_x = 8'd50;
        bus.fire     = 1'b1;
        step(1);
        wait_idle("back_to_back");
        n_checks++;
        if (bus.miss !== 1'b1) begin
            n_fail++;
            $display("FAIL refire_first_end: miss=%b, required 1", bus.miss);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.draw_req, bus.shot_y} !== {1'b1, 1'b1, 7'd10}) begin
            n_fail++;
            $display("FAIL refire_relaunch: busy=%b req=%b y=%0d, required 1 1 10", bus.busy, bus.draw_req, bus.shot_y);
        end
        step(1);
        bus.fire = 1'b0;
        reset    = 1'b1;
        step(2);
        reset    = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL refire_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL refire_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    task automatic test_halt();
        ev_t e, o;
        int  k;
        set_aliens(1'b0, 5, 40, 60);
        push_steps(50, 10, 8);
        launch(50);
        k = 0;
        while (obs_q.size() < 3 && k < 200) begin
            step(1);
            k++;
        end
        n_checks++;
        if (obs_q.size() < 3) begin
            n_fail++;
            $display("FAIL halt_setup timeout: %0d events seen, required 3", obs_q.size());
        end
        bus.halt = 1'b1;
        wait_idle("halt");
        n_checks++;
        if ({bus.hit, bus.miss} !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_no_pulse: hit=%b miss=%b, required 0 0", bus.hit, bus.miss);
        end
        step(1);
        bus.fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_blocks_launch: busy=%b at cycle %0d, required 0", bus.busy, i);
            end
        end
        step(1);
        bus.fire = 1'b0;
        bus.halt = 1'b0;
        step(1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL halt_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    task automatic test_reset_mid_flight();
        ev_t e, o;
        int  k;
        set_aliens(1'b0, 5, 40, 60);
        push_steps(50, 10, 8);
        exp_q.push_back(mk(K_DRAW, 1'b1, 8'd50, 7'd6));
        launch(50);
        k = 0;
        while (!(obs_q.size() >= 5 && bus.erase === 1'b1) && k < 200) begin
            step(1);
            k++;
        end
        n_checks++;
        if (!(obs_q.size() >= 5 && bus.erase === 1'b1)) begin
            n_fail++;
            $display("FAIL rst_mid_setup timeout: events=%0d erase=%b, required 5 and 1", obs_q.size(), bus.erase);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.draw_req, bus.busy, bus.shot_y, bus.hit, bus.miss} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: req=%b busy=%b y=%0d hit=%b miss=%b, required all 0",
                     bus.draw_req, bus.busy, bus.shot_y, bus.hit, bus.miss);
        end
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %0d required %0d", dut.state_q, IDLE);
        end
        step(1);
        reset = 1'b0;
        exp_q.push_back(mk(K_DRAW, 1'b1, 8'd50, 7'd10));
        launch(50);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.draw_req, bus.shot_y} !== {1'b1, 1'b1, 7'd10}) begin
            n_fail++;
            $display("FAIL rst_mid_relaunch: busy=%b req=%b y=%0d, required 1 1 10", bus.busy, bus.draw_req, bus.shot_y);
        end
        step(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_extra: %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        step(2);
    endtask

    initial begin
        test_reset();
        test_miss_path();
        test_hit_path();
        test_span_miss();
        test_back_to_back();
        test_halt();
        test_reset_mid_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
